ppu_line_scheduler: RTL and testbench

- Sequences the whizgraphics renderer across a frame.
- Generates dot and line timing and the per-line drawline request, and consumes renderComplete.
- Drives LY, the STAT mode and the V-blank/STAT interrupt pulses to the CPU side.
- Sits between the LCD register block and the renderer datapath; it is the only source of drawline.

---
 rtl/ppu_line_scheduler.sv | 91 +++++++++
 tb/tb_ppu_line_scheduler.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/ppu_line_scheduler.sv
// ppu_line_scheduler: dot/line timing, drawline requests, STAT mode and interrupts.
// Define OVERRUN_STALL_EN to stall the line end until the renderer finishes.
module ppu_line_scheduler #(
  parameter int DOTS_PER_LINE = 456,
  parameter int OAM_DOTS      = 80,
  parameter int VISIBLE_LINES = 144,
  parameter int TOTAL_LINES   = 154
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       lcd_enable,
  input  logic [7:0] lyc,
  input  logic [3:0] stat_en,
  input  logic       render_complete,
  output logic       drawline,
  output logic [7:0] ly,
  output logic [1:0] mode,
  output logic       lyc_match,
  output logic       vblank_irq,
  output logic       stat_irq,
  output logic       overrun
);
  localparam int DW = $clog2(DOTS_PER_LINE);
  localparam logic [1:0] HBLANK = 2'd0, VBLANK = 2'd1, OAM = 2'd2, XFER = 2'd3;
  logic [DW-1:0] dot_q, dot_d;
  logic [7:0] ly_q, ly_d;
  logic [1:0] st_q, st_d;
  logic en_q, drawline_q, drawline_d, vblank_q, vblank_d, stat_q, stat_d;
  logic or_q, or_d, overrun_q, overrun_d, last, hold, wrap;
  always_comb begin
    last = dot_q == DW'(DOTS_PER_LINE - 1);
`ifdef OVERRUN_STALL_EN
    hold = last && st_q == XFER;
`else
    hold = 1'b0;
`endif
    wrap = en_q && last && !hold;
    ly_d = !en_q ? 8'd0 : !wrap ? ly_q : ly_q == 8'(TOTAL_LINES - 1) ? 8'd0 : ly_q + 8'd1;
    dot_d = (!en_q || wrap) ? '0 : hold ? dot_q : dot_q + 1'b1;
    drawline_d = en_q && st_q == OAM && dot_q == DW'(OAM_DOTS - 1);
    st_d = !en_q ? OAM
         : wrap ? (ly_d < 8'(VISIBLE_LINES) ? OAM : VBLANK)
         : drawline_d ? XFER
         : (st_q == XFER && !drawline_q && render_complete) ? HBLANK : st_q;
    vblank_d = wrap && ly_d == 8'(VISIBLE_LINES);
    or_d = (st_d == HBLANK && stat_en[0]) || (st_d == VBLANK && stat_en[1]) ||
           (st_d == OAM && stat_en[2]) || (ly_d == lyc && stat_en[3]);
    stat_d = or_d && !or_q;
    overrun_d = overrun_q || (dot_d == DW'(DOTS_PER_LINE - 1) && st_d == XFER);
  end
  // or_q idles high so enabling the LCD never produces a spurious STAT edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en_q <= 1'b0;
      dot_q <= '0;
      ly_q <= 8'd0;
      st_q <= HBLANK;
      drawline_q <= 1'b0;
      vblank_q <= 1'b0;
      stat_q <= 1'b0;
      or_q <= 1'b1;
      overrun_q <= 1'b0;
    end else if (!lcd_enable) begin
      en_q <= 1'b0;
      dot_q <= '0;
      ly_q <= 8'd0;
      st_q <= HBLANK;
      drawline_q <= 1'b0;
      vblank_q <= 1'b0;
      stat_q <= 1'b0;
      or_q <= 1'b1;
    end else begin
      en_q <= 1'b1;
      dot_q <= dot_d;
      ly_q <= ly_d;
      st_q <= st_d;
      drawline_q <= drawline_d;
      vblank_q <= vblank_d;
      stat_q <= stat_d;
      or_q <= or_d;
      overrun_q <= overrun_d;
    end
  end
  assign drawline = drawline_q;
  assign ly = ly_q;
  assign mode = st_q;
  assign lyc_match = ly_q == lyc;
  assign vblank_irq = vblank_q;
  assign stat_irq = stat_q;
  assign overrun = overrun_q;
endmodule

// File: tb/tb_ppu_line_scheduler.sv
// tb_ppu_line_scheduler: directed checks of frame timing, interrupts, overrun and reset abort.
module tb_ppu_line_scheduler;
  logic clk = 1'b0, rst = 1'b1, lcd_enable = 1'b1, render_complete = 1'b0;
  logic [7:0] lyc = 8'd5;
  logic [3:0] stat_en = 4'b1000;
  logic drawline, lyc_match, vblank_irq, stat_irq, overrun;
  logic [7:0] ly;
  logic [1:0] mode;
  int checks = 0, failures = 0;
  int cyc = -1, dl_cnt = 1000, rc_delay = 100, hold_ly = 255;
  logic rc_force = 1'b0;

  ppu_line_scheduler dut (
    .clk(clk), .rst(rst), .lcd_enable(lcd_enable), .lyc(lyc), .stat_en(stat_en),
    .render_complete(render_complete), .drawline(drawline), .ly(ly), .mode(mode),
    .lyc_match(lyc_match), .vblank_irq(vblank_irq), .stat_irq(stat_irq), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
    if (drawline) dl_cnt = 0;
    else dl_cnt++;
    render_complete = rc_force | (rc_delay >= 0 && dl_cnt == rc_delay && int'(ly) != hold_ly);
  endtask

  task automatic restart();
    lcd_enable = 1'b0;
    tick();
    tick();
    chk("idle_mode", int'(mode), 0);
    chk("idle_ly", int'(ly), 0);
    lcd_enable = 1'b1;
    dl_cnt = 1000;
    cyc = -1;
  endtask

  int first_dl, first_m3, first_m0, first_ly1, first_wrap, dl_count, vb_count, vb_cyc, vb_mode;
  int st_count, st_cyc, ovr_seen, lm5, lm6;

  initial begin
    first_dl = -1; first_m3 = -1; first_m0 = -1; first_ly1 = -1; first_wrap = -1;
    dl_count = 0; vb_count = 0; vb_cyc = -1; vb_mode = -1; st_count = 0; st_cyc = -1;
    ovr_seen = 0; lm5 = -1; lm6 = -1;
    lyc = 8'd5;
    stat_en = 4'b1000;
    repeat (2) @(negedge clk);
    chk("rst_drawline", int'(drawline), 0);
    chk("rst_ly", int'(ly), 0);
    chk("rst_mode", int'(mode), 0);
    chk("rst_irqs", int'({vblank_irq, stat_irq, overrun}), 0);
    chk("rst_lyc_match", int'(lyc_match), 0);
    rst = 1'b0;
    cyc = -1;
    // full frame with 100-cycle renderer latency
    while (cyc < 154 * 456) begin
      tick();
      if (cyc == 0) chk("cyc0_mode", int'(mode), 2);
      if (drawline) begin
        dl_count++;
        if (first_dl < 0) first_dl = cyc;
      end
      if (mode == 2'd3 && first_m3 < 0) first_m3 = cyc;
      if (mode == 2'd0 && first_m3 >= 0 && first_m0 < 0) first_m0 = cyc;
      if (ly == 8'd1 && first_ly1 < 0) first_ly1 = cyc;
      if (ly == 8'd0 && cyc > 456 && first_wrap < 0) first_wrap = cyc;
      if (vblank_irq) begin
        vb_count++;
        vb_cyc = cyc;
        vb_mode = int'(mode);
      end
      if (stat_irq) begin
        st_count++;
        st_cyc = cyc;
      end
      if (overrun) ovr_seen = 1;
      if (cyc == 5 * 456) lm5 = int'(lyc_match);
      if (cyc == 6 * 456) lm6 = int'(lyc_match);
      if (cyc == 154 * 456 - 1) chk("ly_before_wrap", int'(ly), 153);
    end
    chk("first_drawline", first_dl, 80);
    chk("mode3_entry", first_m3, 80);
    chk("mode0_entry", first_m0, 181);
    chk("ly1_cycle", first_ly1, 456);
    chk("drawline_count", dl_count, 144);
    chk("vblank_count", vb_count, 1);
    chk("vblank_cycle", vb_cyc, 144 * 456);
    chk("vblank_mode", vb_mode, 1);
    chk("frame_wrap", first_wrap, 154 * 456);
    chk("lyc_stat_count", st_count, 1);
    chk("lyc_stat_cycle", st_cyc, 5 * 456);
    chk("lyc_match_l5", lm5, 1);
    chk("lyc_match_l6", lm6, 0);
    chk("no_overrun", ovr_seen, 0);

    // hblank+oam enables: OR stays high across hblank->oam
    lyc = 8'd200;
    stat_en = 4'b0101;
    rc_delay = 1;
    restart();
    st_count = 0;
    st_cyc = -1;
    while (cyc < 456 + 80) begin
      tick();
      if (stat_irq) begin
        st_count++;
        if (st_cyc < 0) st_cyc = cyc;
      end
    end
    chk("hb_oam_stat_count", st_count, 1);
    chk("hb_oam_stat_cycle", st_cyc, 82);

    // renderer never finishes line 3
    stat_en = 4'b0000;
    rc_delay = 100;
    hold_ly = 3;
    restart();
    while (cyc < 3 * 456 + 454) tick();
    chk("ovr_before", int'(overrun), 0);
    tick();
    chk("ovr_set", int'(overrun), 1);
    chk("ovr_mode", int'(mode), 3);
    tick();
`ifdef OVERRUN_STALL_EN
    chk("ovr_next_ly", int'(ly), 3);
    chk("ovr_next_mode", int'(mode), 3);
`else
    chk("ovr_next_ly", int'(ly), 4);
    chk("ovr_next_mode", int'(mode), 2);
`endif
    while (cyc < 3 * 456 + 462) tick();
    rc_force = 1'b1;
    render_complete = 1'b1;
    tick();
    rc_force = 1'b0;
    render_complete = 1'b0;
`ifdef OVERRUN_STALL_EN
    chk("late_rc_mode", int'(mode), 0);
    chk("late_rc_ly", int'(ly), 3);
`else
    chk("late_rc_mode", int'(mode), 2);
    chk("late_rc_ly", int'(ly), 4);
`endif
    tick();
    chk("after_ovr_ly", int'(ly), 4);
    chk("after_ovr_mode", int'(mode), 2);
    restart();
    chk("ovr_sticky_idle", int'(overrun), 1);

    // reset mid-transfer on line 10, then a late render_complete
    rc_delay = -1;
    hold_ly = 255;
    while (cyc < 10 * 456 + 100) tick();
    chk("l10_xfer", int'(mode), 3);
    chk("l10_ly", int'(ly), 10);
    rst = 1'b1;
    #1;
    chk("abort_ly", int'(ly), 0);
    chk("abort_mode", int'(mode), 0);
    chk("abort_outs", int'({drawline, vblank_irq, stat_irq, overrun}), 0);
    @(negedge clk);
    rst = 1'b0;
    rc_force = 1'b1;
    render_complete = 1'b1;
    cyc = -1;
    while (cyc < 5) begin
      tick();
      chk("post_rst_mode", int'(mode), 2);
    end
    chk("post_rst_ly", int'(ly), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
